simple_pipe_issuer: RTL and testbench

Instruction issue front-end for the 4-register add/sub/and pipeline: accepts 8-bit instructions from a host over a valid/ready handshake, buffers them in a small FIFO, and drives the pipeline's `inst` and `__START__` inputs one instruction per advancing cycle. It inserts NOPs when the buffer is empty and tracks in-flight register writes, so the host knows when all issued results have been committed to the register file.

---
 rtl/simple_pipe_issuer.sv | 116 +++++++++++
 tb/tb_simple_pipe_issuer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/simple_pipe_issuer.sv
// Issue front-end for the 4-register add/sub/and pipeline: FIFO-buffered host
// instructions, NOP bubbles on empty, in-flight write tracking.
// Optional issued-instruction counter enabled by SIMPLE_PIPE_ISSUE_CNT_EN.
module simple_pipe_issuer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_inst,
    output logic                     in_ready,
    input  logic                     go,
    output logic [7:0]               inst,
    output logic                     start,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drained
`ifdef SIMPLE_PIPE_ISSUE_CNT_EN
    ,
    output logic [CNT_W-1:0]         issued_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    inst_q, inst_d;
    logic          start_q, start_d;
    logic [2:0]    wsr_q, wsr_d;
    logic          push;
    logic          pop;

    always_comb begin
        push = in_valid && (count_q < FULL_CNT);
        pop  = go && (count_q != '0);

        mem_d = mem_q;
        if (push) begin
            mem_d[tail_q] = in_inst;
        end

        tail_d = push ? tail_q + 1'b1 : tail_q;
        head_d = pop  ? head_q + 1'b1 : head_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // An empty FIFO with go=1 still strobes start so the pipeline keeps draining.
        inst_d  = pop ? mem_q[head_q] : '0;
        start_d = go;

        wsr_d = start_q ? {wsr_q[1:0], inst_q[7:6] != 2'b00} : wsr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            inst_q  <= '0;
            start_q <= 1'b0;
            wsr_q   <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            inst_q  <= inst_d;
            start_q <= start_d;
            wsr_q   <= wsr_d;
        end
    end

`ifdef SIMPLE_PIPE_ISSUE_CNT_EN
    logic [CNT_W-1:0] issued_q, issued_d;

    always_comb begin
        issued_d = issued_q;
        if (pop && (mem_q[head_q][7:6] != 2'b00)) begin
            issued_d = issued_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_q <= '0;
        end else begin
            issued_q <= issued_d;
        end
    end

    assign issued_cnt = issued_q;
`else
    // CNT_W only sizes the counter; referenced here so the default build stays warning-free.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

    assign in_ready = count_q < FULL_CNT;
    assign inst     = inst_q;
    assign start    = start_q;
    assign count    = count_q;
    assign drained  = (count_q == '0) && (wsr_q == '0) && (inst_q[7:6] == 2'b00);

endmodule

// File: tb/tb_simple_pipe_issuer.sv
// Directed self-checking bench for simple_pipe_issuer (DEPTH=4); counter checks
// are active when SIMPLE_PIPE_ISSUE_CNT_EN is defined.
module tb_simple_pipe_issuer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_inst;
    logic       in_ready;
    logic       go;
    logic [7:0] inst;
    logic       start;
    logic [2:0] count;
    logic       drained;
`ifdef SIMPLE_PIPE_ISSUE_CNT_EN
    logic [15:0] issued_cnt;
`endif

    int n_tests;
    int n_fail;

    simple_pipe_issuer #(.DEPTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .go        (go),
        .inst      (inst),
        .start     (start),
        .count     (count),
        .drained   (drained)
`ifdef SIMPLE_PIPE_ISSUE_CNT_EN
        ,
        .issued_cnt(issued_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_inst  = 8'h00;
        go       = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    logic [7:0] stream_v [8];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        stream_v[0] = 8'h41; stream_v[1] = 8'h95; stream_v[2] = 8'hE2; stream_v[3] = 8'h5B;
        stream_v[4] = 8'hA8; stream_v[5] = 8'hCF; stream_v[6] = 8'h76; stream_v[7] = 8'h9D;

        // reset and idle
        do_reset();
        step();
        step();
        check("idle_inst", inst, 8'h00);
        check("idle_start", start, 0);
        check("idle_count", count, 0);
        check("idle_ready", in_ready, 1);
        check("idle_drained", drained, 1);
`ifdef SIMPLE_PIPE_ISSUE_CNT_EN
        check("idle_issued", issued_cnt, 0);
`endif

        // fill to full with go=0, fifth push refused
        in_valid = 1'b1;
        in_inst = 8'h41; step();
        in_inst = 8'h86; step();
        in_inst = 8'hC7; step();
        in_inst = 8'h12; step();
        check("full_count", count, 4);
        check("full_ready", in_ready, 0);
        in_inst = 8'hFF; step();
        check("full_refuse_count", count, 4);
        check("full_start", start, 0);
        in_valid = 1'b0;
        go = 1'b1;
        step(); check("drain0", inst, 8'h41); check("drain0_start", start, 1);
        step(); check("drain1", inst, 8'h86);
        step(); check("drain2", inst, 8'hC7);
        step(); check("drain3", inst, 8'h12); check("drain3_count", count, 0);
        check("drain3_drained", drained, 0);
        step(); check("drain_bubble", inst, 8'h00); check("drain_bubble_start", start, 1);
        step(); check("drain_e6_drained", drained, 0);
        step(); check("drain_e7_drained", drained, 1);
`ifdef SIMPLE_PIPE_ISSUE_CNT_EN
        check("drain_issued", issued_cnt, 3);
`endif

        // single ADD with go held high
        do_reset();
        go = 1'b1;
        in_valid = 1'b1;
        in_inst = 8'h41;
        step();
        check("add_push_inst", inst, 8'h00);
        check("add_push_start", start, 1);
        check("add_push_count", count, 1);
        in_valid = 1'b0;
        step();
        check("add_issue_inst", inst, 8'h41);
        check("add_issue_start", start, 1);
        check("add_issue_drained", drained, 0);
        step(); check("add_e1_drained", drained, 0);
        step(); check("add_e2_drained", drained, 0);
        step(); check("add_e3_drained", drained, 0);
        step(); check("add_e4_drained", drained, 1);

        // streaming at full rate
        do_reset();
        go = 1'b1;
        for (int k = 0; k < 9; k++) begin
            in_valid = (k < 8);
            in_inst  = (k < 8) ? stream_v[k] : 8'h00;
            step();
            if (k == 0) check("stream_first", inst, 8'h00);
            else        check($sformatf("stream_%0d", k - 1), inst, stream_v[k - 1]);
            check($sformatf("stream_count_%0d", k), count, (k < 8) ? 1 : 0);
            check("stream_start", start, 1);
        end
`ifdef SIMPLE_PIPE_ISSUE_CNT_EN
        check("stream_issued", issued_cnt, 8);
`endif

        // go toggling with two writers queued
        do_reset();
        in_valid = 1'b1;
        in_inst = 8'h47; step();
        in_inst = 8'hBA; step();
        in_valid = 1'b0;
        check("tog_count", count, 2);
        go = 1'b1; step(); check("tog_i0", inst, 8'h47); check("tog_s0", start, 1);
        go = 1'b0; step(); check("tog_i1", inst, 8'h00); check("tog_s1", start, 0);
        go = 1'b1; step(); check("tog_i2", inst, 8'hBA); check("tog_s2", start, 1);
        go = 1'b0; step(); check("tog_i3", inst, 8'h00); check("tog_s3", start, 0);
        step(); step(); step();
        check("tog_hold_drained", drained, 0);
        go = 1'b1;
        step(); check("tog_b1_drained", drained, 0);
        step(); check("tog_b2_drained", drained, 0);
        step(); check("tog_b3_drained", drained, 0);
        step(); check("tog_b4_drained", drained, 1);
`ifdef SIMPLE_PIPE_ISSUE_CNT_EN
        check("tog_issued", issued_cnt, 2);
`endif

        // async reset with count=3, wsr=101
        do_reset();
        in_valid = 1'b1; in_inst = 8'h41; go = 1'b0; step();
        in_valid = 1'b0; go = 1'b1; step();
        in_valid = 1'b1; in_inst = 8'h86; step();
        in_inst = 8'hC7; step();
        go = 1'b0; in_inst = 8'h5B; step();
        in_inst = 8'hA8; step();
        in_valid = 1'b0;
        check("mid_count", count, 3);
        check("mid_drained", drained, 0);
`ifdef SIMPLE_PIPE_ISSUE_CNT_EN
        check("mid_issued", issued_cnt, 2);
`endif
        #2;
        rst = 1'b1;
        #1;
        check("arst_inst", inst, 8'h00);
        check("arst_start", start, 0);
        check("arst_count", count, 0);
        check("arst_ready", in_ready, 1);
        check("arst_drained", drained, 1);
`ifdef SIMPLE_PIPE_ISSUE_CNT_EN
        check("arst_issued", issued_cnt, 0);
`endif
        #1;
        rst = 1'b0;
        step();
        check("post_count", count, 0);
        go = 1'b1; step();
        check("post_bubble_inst", inst, 8'h00);
        check("post_bubble_start", start, 1);
        in_valid = 1'b1; in_inst = 8'h41; step();
        in_valid = 1'b0; step();
        check("post_issue_inst", inst, 8'h41);
`ifdef SIMPLE_PIPE_ISSUE_CNT_EN
        check("post_issued", issued_cnt, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
